nabp_angle_sequencer: RTL

NABP_ANGLE_SEQUENCER -- requirements
Module: nabp_angle_sequencer

---
 rtl/nabp_angle_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/nabp_angle_sequencer.sv
// nabp_angle_sequencer
// Issues a sequence of projection angles to a consumer over a four-phase
// request/acknowledge handshake. Angles start at cfg_first_angle and advance by
// cfg_angle_step, wrapping modulo cfg_angle_max. The sequence length is
// cfg_no_of_angles.
//
// Ports
//   clk               : clock, rising edge
//   reset             : synchronous active-high reset
//   cfg_start         : pulse, starts a sequence (IDLE only)
//   cfg_abort         : pulse, abandons the current sequence (READY/ACK only)
//   cfg_first_angle   : first angle issued
//   cfg_angle_step    : increment between angles
//   cfg_angle_max     : wrap modulus
//   cfg_no_of_angles  : number of angles to issue
//   hs_next_angle     : consumer request (four-phase)
//   hs_next_angle_ack : producer acknowledge (four-phase)
//   hs_angle          : issued angle, held between acknowledges
//   hs_has_next_angle : at least one further angle remains
//   busy              : high outside IDLE
//   done              : one-cycle pulse on normal completion
//   cfg_error         : sticky illegal-configuration flag
//   db_angle_index    : angles issued so far in the current sequence
module nabp_angle_sequencer #(
    parameter int unsigned pAngleLength = 8,
    parameter int unsigned pCountLength = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cfg_start,
    input  logic                    cfg_abort,
    input  logic [pAngleLength-1:0] cfg_first_angle,
    input  logic [pAngleLength-1:0] cfg_angle_step,
    input  logic [pAngleLength-1:0] cfg_angle_max,
    input  logic [pCountLength-1:0] cfg_no_of_angles,
    input  logic                    hs_next_angle,
    output logic                    hs_next_angle_ack,
    output logic [pAngleLength-1:0] hs_angle,
    output logic                    hs_has_next_angle,
    output logic                    busy,
    output logic                    done,
    output logic                    cfg_error,
    output logic [pCountLength-1:0] db_angle_index
);

    typedef enum logic [1:0] {StIdle, StReady, StAck} state_e;

    state_e                  state_q;
    logic [pAngleLength-1:0] cur_angle_q;
    logic [pAngleLength-1:0] step_q;
    logic [pAngleLength-1:0] max_q;
    logic [pAngleLength-1:0] angle_q;
    logic [pCountLength-1:0] remaining_q;
    logic [pCountLength-1:0] index_q;
    logic                    ack_q;
    logic                    has_next_q;
    logic                    done_q;
    logic                    err_q;

    // One extra bit on the sum so cur + step cannot overflow before the compare.
    logic [pAngleLength:0]   sum;
    logic [pAngleLength:0]   diff;
    logic [pAngleLength-1:0] next_angle;
    logic [pCountLength-1:0] remaining_dec;
    logic                    cfg_bad;

    always_comb begin
        sum  = {1'b0, cur_angle_q} + {1'b0, step_q};
        diff = sum - {1'b0, max_q};
        if (sum >= {1'b0, max_q}) begin
            next_angle = diff[pAngleLength-1:0];
        end else begin
            next_angle = sum[pAngleLength-1:0];
        end
        remaining_dec = remaining_q - pCountLength'(1);
        // Both operands below max guarantees the wrapped sum stays below max.
        cfg_bad = (cfg_first_angle >= cfg_angle_max) || (cfg_angle_step >= cfg_angle_max);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cur_angle_q <= '0;
            step_q      <= '0;
            max_q       <= '0;
            angle_q     <= '0;
            remaining_q <= '0;
            index_q     <= '0;
            ack_q       <= 1'b0;
            has_next_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // Start wins over abort here; abort has no meaning in IDLE.
                    if (cfg_start) begin
                        cur_angle_q <= cfg_first_angle;
                        step_q      <= cfg_angle_step;
                        max_q       <= cfg_angle_max;
                        remaining_q <= cfg_no_of_angles;
                        if (cfg_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            err_q <= 1'b0;
                            if (cfg_no_of_angles == '0) begin
                                done_q <= 1'b1;
                            end else begin
                                state_q    <= StReady;
                                has_next_q <= 1'b1;
                                index_q    <= '0;
                            end
                        end
                    end
                end
                StReady: begin
                    if (cfg_abort) begin
                        state_q    <= StIdle;
                        has_next_q <= 1'b0;
                        ack_q      <= 1'b0;
                    end else if (hs_next_angle) begin
                        angle_q     <= cur_angle_q;
                        ack_q       <= 1'b1;
                        remaining_q <= remaining_dec;
                        index_q     <= index_q + pCountLength'(1);
                        cur_angle_q <= next_angle;
                        has_next_q  <= (remaining_dec != '0);
                        state_q     <= StAck;
                    end
                end
                StAck: begin
                    if (cfg_abort) begin
                        state_q    <= StIdle;
                        has_next_q <= 1'b0;
                        ack_q      <= 1'b0;
                    end else if (!hs_next_angle) begin
                        ack_q <= 1'b0;
                        if (remaining_q != '0) begin
                            state_q <= StReady;
                        end else begin
                            state_q <= StIdle;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign hs_next_angle_ack = ack_q;
    assign hs_angle          = angle_q;
    assign hs_has_next_angle = has_next_q;
    assign busy              = (state_q != StIdle);
    assign done              = done_q;
    assign cfg_error         = err_q;
    assign db_angle_index    = index_q;

endmodule
